fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Sequencing controller for the instruction fetch path.
- Owns the 64-bit program counter and drives the address of the combinational instruction memory.
- Registers each fetched word into a valid/ready output stage for decode.
- Handles pipeline stalls, branch/jump/trap redirects with flush, and misaligned-target faults.
- Sits between the instruction memory and the decode stage of the 64-bit core.

Parameters:
XLEN, 64, width of PC and redirect target.
RESET_VECTOR, 64'h0, PC value loaded on reset.
NOP_INSTR, 32'h00000013, value of out_instr while no valid instruction is held.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
imem_addr  out  XLEN  fetch address to instruction memory; always equals the internal PC register.
imem_rdata  in  32  instruction word, combinational from imem_addr.
stall  in  1  hazard hold; no new fetch is captured while high.
redirect_valid  in  1  one-cycle pulse: branch taken, jump or trap.
redirect_target  in  XLEN  new PC when redirect_valid=1.
out_valid  out  1  out_pc/out_instr hold a valid instruction.
out_ready  in  1  decode accepts the instruction this cycle.
out_pc  out  XLEN  PC of the held instruction.
out_instr  out  32  held instruction word.
misalign_fault  out  1  sticky: last redirect target was not 4-byte aligned.
fault_addr  out  XLEN  offending redirect target.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pc=RESET_VECTOR, state=BOOT.
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR.
  - misalign_fault=0, fault_addr=0.
- FSM states:
  - BOOT: one cycle after reset release, no capture. Next state RUN, unless redirect_valid=1 (redirect rules apply).
  - RUN: normal fetch.
  - FAULT: no fetch; out_valid held at 0; PC frozen.
- Capture condition in RUN: cap = !stall && (!out_valid || out_ready).
- When cap=1, at the clock edge:
  - out_pc<=pc, out_instr<=imem_rdata, out_valid<=1.
  - pc<=pc+4, modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Latency: the instruction is visible on out_* one cycle after its address is on imem_addr. Sustained throughput is 1 instruction/cycle when stall=0 and out_ready=1.
- Holding rules in RUN when cap=0:
  - out_valid=1 && out_ready=0: out_* and pc hold unchanged, regardless of stall.
  - out_valid=1 && out_ready=1 && stall=1: out_valid<=0, out_instr<=NOP_INSTR, pc holds.
  - out_valid=0 && stall=1: everything holds.
- Redirect has highest priority, in any state, and overrides cap, stall and out_ready:
  - Flush: out_valid<=0, out_instr<=NOP_INSTR. The instruction held that cycle is discarded even if out_ready=1.
  - Aligned target (target[1:0]==0): pc<=target, state<=RUN, misalign_fault<=0. Capture resumes next cycle, so the first post-redirect instruction appears 2 cycles after the pulse.
  - Misaligned target: pc unchanged, fault_addr<=target, misalign_fault<=1, state<=FAULT.
- FAULT is left only by an aligned redirect (trap vector) or reset. A misaligned redirect in FAULT updates fault_addr and stays in FAULT.
- Simultaneous stall and redirect: the redirect wins; the stall is ignored that cycle.
- Reset asserted mid-stream: all registers return to reset values immediately; no partial capture.
- Combinational paths: out_valid, out_pc and out_instr have no combinational path from inputs. imem_addr is driven directly from the pc register.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output ports perf_fetched (64 bits) and perf_stall_cycles (64 bits), both reset to 0.
  - perf_fetched increments on every cap=1 edge with no redirect that cycle.
  - perf_stall_cycles increments on every RUN-state cycle with stall=1.
  - Both counters wrap modulo 2^64.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
1. Reset release, RESET_VECTOR=0, stall=0, out_ready=1, imem returns addr-based words:
   - cycle 1: BOOT, out_valid=0.
   - then out_pc follows 0,4,8,12 with out_valid=1 on consecutive cycles.
2. Backpressure: out_ready=0 for 3 cycles while out_pc=8 → out_pc=8 and out_instr stable, imem_addr=12 held. On out_ready=1, the next two cycles present 12, then 16.
3. Stall with consumption: out_valid=1, out_ready=1, stall=1 for 2 cycles → out_valid drops to 0, out_instr=32'h00000013, pc held. On stall release, fetch resumes at the held pc.
4. Redirect pulse to 64'h1000 while holding pc 0x20 with out_ready=0 → next cycle out_valid=0, imem_addr=0x1000; the following cycle out_pc=0x1000.
5. Misaligned redirect to 64'h1002 → misalign_fault=1, fault_addr=0x1002, out_valid stays 0 for 5 cycles. A redirect to 64'h200 clears the fault, and out_pc=0x200 appears 2 cycles later.
6. Wrap-around: redirect to 64'hFFFF_FFFF_FFFF_FFF8 → out_pc sequence FFF8, FFFC, 0, 4. With FETCH_PERF_CNT_EN defined, perf_fetched=4 after these captures.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC and registers each fetched word into a
// valid/ready stage for decode. Optional perf counters are enabled by FETCH_PERF_CNT_EN.
module fetch_sequencer #(
    parameter int                XLEN         = 64,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter logic [31:0]       NOP_INSTR    = 32'h0000_0013
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            misalign_fault,
    output logic [XLEN-1:0] fault_addr,
    output logic [1:0]      dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]     perf_fetched,
    output logic [63:0]     perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic            cap;

    // Output handshake: a word transfers to decode on a cycle where out_valid and
    // out_ready are both high; while out_valid=1 and out_ready=0 the word and PC
    // are frozen. A new word is captured only when the slot is empty or draining.
    assign cap = (state_q == RUN) && !stall && (!out_valid_q || out_ready);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;

        if (redirect_valid) begin
            // Redirect flushes the held word even if decode is taking it this cycle.
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
            if (redirect_target[1:0] == 2'b00) begin
                pc_d    = redirect_target;
                state_d = RUN;
                fault_d = 1'b0;
            end else begin
                fault_addr_d = redirect_target;
                fault_d      = 1'b1;
                state_d      = FAULT;
            end
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (cap) begin
                        out_pc_d    = pc_q;
                        out_instr_d = imem_rdata;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + XLEN'(4);
                    end else if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        out_instr_d = NOP_INSTR;
                    end
                end
                default: begin
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_instr_q  <= NOP_INSTR;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign imem_addr      = pc_q;
    assign out_valid      = out_valid_q;
    assign out_pc         = out_pc_q;
    assign out_instr      = out_instr_q;
    assign misalign_fault = fault_q;
    assign fault_addr     = fault_addr_q;
    assign dbg_state      = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perf_fetched_q, perf_fetched_d;
    logic [63:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (cap && !redirect_valid)
            perf_fetched_d = perf_fetched_q + 64'd1;
        if ((state_q == RUN) && stall)
            perf_stall_d = perf_stall_q + 64'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for the main stream plus
// hand-written sequences for fault re-entry, redirect in BOOT, wrap-around and async reset.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_FAULT = 2'd2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall, redirect_valid, out_ready;
  logic [63:0] redirect_target;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign_fault;
  logic [63:0] fault_addr;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetched, perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .misalign_fault  (misalign_fault),
    .fault_addr      (fault_addr),
    .dbg_state       (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Clock / memory stub
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic rv, input logic [63:0] tgt);
    stall = s;
    out_ready = r;
    redirect_valid = rv;
    redirect_target = tgt;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [63:0] pc);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    if (v) begin
      check({tag, ".out_pc"}, out_pc, pc);
      check({tag, ".out_instr"}, 64'(out_instr), 64'(mem_word(pc)));
    end else begin
      check({tag, ".out_instr_nop"}, 64'(out_instr), 64'(NOP));
    end
  endtask

  typedef struct {
    logic        stall;
    logic        ready;
    logic        redir;
    logic [63:0] target;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic [63:0] exp_addr;
    logic        exp_fault;
    logic [63:0] exp_faddr;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic r, input logic rv, input logic [63:0] tgt,
                     input logic v, input logic [63:0] pc, input logic [63:0] addr,
                     input logic f, input logic [63:0] fa, input logic [1:0] st);
    vec_t e;
    e = '{s, r, rv, tgt, v, pc, addr, f, fa, st};
    vecs.push_back(e);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset-release stream, backpressure, stall with consumption, aligned and misaligned redirects
    add(0,1,0,64'h0,    0,64'h0,   64'h0,    0,64'h0,    S_RUN);   // BOOT edge, no capture
    add(0,1,0,64'h0,    1,64'h0,   64'h4,    0,64'h0,    S_RUN);
    add(0,1,0,64'h0,    1,64'h4,   64'h8,    0,64'h0,    S_RUN);
    add(0,1,0,64'h0,    1,64'h8,   64'hC,    0,64'h0,    S_RUN);
    add(0,0,0,64'h0,    1,64'h8,   64'hC,    0,64'h0,    S_RUN);
    add(0,0,0,64'h0,    1,64'h8,   64'hC,    0,64'h0,    S_RUN);
    add(0,0,0,64'h0,    1,64'h8,   64'hC,    0,64'h0,    S_RUN);
    add(0,1,0,64'h0,    1,64'hC,   64'h10,   0,64'h0,    S_RUN);
    add(0,1,0,64'h0,    1,64'h10,  64'h14,   0,64'h0,    S_RUN);
    add(1,1,0,64'h0,    0,64'h0,   64'h14,   0,64'h0,    S_RUN);   // drained, no refill
    add(1,1,0,64'h0,    0,64'h0,   64'h14,   0,64'h0,    S_RUN);
    add(0,1,0,64'h0,    1,64'h14,  64'h18,   0,64'h0,    S_RUN);
    add(0,1,0,64'h0,    1,64'h18,  64'h1C,   0,64'h0,    S_RUN);
    add(0,1,0,64'h0,    1,64'h1C,  64'h20,   0,64'h0,    S_RUN);
    add(0,0,1,64'h1000, 0,64'h0,   64'h1000, 0,64'h0,    S_RUN);   // redirect flushes held word
    add(0,1,0,64'h0,    1,64'h1000,64'h1004, 0,64'h0,    S_RUN);
    add(0,1,1,64'h1002, 0,64'h0,   64'h1004, 1,64'h1002, S_FAULT);
    for (int i = 0; i < 5; i++)
      add(0,1,0,64'h0,  0,64'h0,   64'h1004, 1,64'h1002, S_FAULT);
    add(0,1,1,64'h200,  0,64'h0,   64'h200,  0,64'h1002, S_RUN);
    add(0,1,0,64'h0,    1,64'h200, 64'h204,  0,64'h1002, S_RUN);

    do_reset();
    check("reset.out_valid", 64'(out_valid), 64'h0);
    check("reset.out_pc", out_pc, 64'h0);
    check("reset.out_instr", 64'(out_instr), 64'(NOP));
    check("reset.imem_addr", imem_addr, 64'h0);
    check("reset.fault", 64'(misalign_fault), 64'h0);
    check("reset.fault_addr", fault_addr, 64'h0);
    check("reset.state_boot", 64'(dbg_state), 64'(S_BOOT));

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].stall, vecs[i].ready, vecs[i].redir, vecs[i].target);
      step();
      check_out(tag, vecs[i].exp_valid, vecs[i].exp_pc);
      check({tag, ".imem_addr"}, imem_addr, vecs[i].exp_addr);
      check({tag, ".fault"}, 64'(misalign_fault), 64'(vecs[i].exp_fault));
      check({tag, ".fault_addr"}, fault_addr, vecs[i].exp_faddr);
      check({tag, ".state"}, 64'(dbg_state), 64'(vecs[i].exp_state));
    end
`ifdef FETCH_PERF_CNT_EN
    check("table.perf_fetched", perf_fetched, 64'd10);
    check("table.perf_stall", perf_stall_cycles, 64'd2);
`endif

    // Misaligned redirect while already faulted, then stall+redirect exits the fault
    drive(0, 1, 1, 64'h3);
    step();
    check("faultA.fault_addr", fault_addr, 64'h3);
    check("faultA.state", 64'(dbg_state), 64'(S_FAULT));
    check_out("faultA", 1'b0, 64'h0);
    drive(0, 1, 1, 64'h7);
    step();
    check("faultB.fault_addr", fault_addr, 64'h7);
    check("faultB.state", 64'(dbg_state), 64'(S_FAULT));
    check("faultB.imem_addr", imem_addr, 64'h204);
    drive(1, 1, 1, 64'h400);
    step();
    check("stallredir.fault", 64'(misalign_fault), 64'h0);
    check("stallredir.imem_addr", imem_addr, 64'h400);
    check("stallredir.state", 64'(dbg_state), 64'(S_RUN));
    check_out("stallredir", 1'b0, 64'h0);
    drive(0, 1, 0, 64'h0);
    step();
    check_out("resume400", 1'b1, 64'h400);
    check("resume400.imem_addr", imem_addr, 64'h404);
`ifdef FETCH_PERF_CNT_EN
    check("faultseq.perf_fetched", perf_fetched, 64'd11);
    check("faultseq.perf_stall", perf_stall_cycles, 64'd2);
`endif

    // Fresh reset, redirect during BOOT, then PC wrap-around
    do_reset();
    drive(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    step();
    check("bootredir.state", 64'(dbg_state), 64'(S_RUN));
    check("bootredir.imem_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    check_out("bootredir", 1'b0, 64'h0);
    drive(0, 1, 0, 64'h0);
    step();
    check_out("wrap0", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    step();
    check_out("wrap1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap1.imem_addr", imem_addr, 64'h0);
    step();
    check_out("wrap2", 1'b1, 64'h0);
    step();
    check_out("wrap3", 1'b1, 64'h4);
    check("wrap3.imem_addr", imem_addr, 64'h8);
`ifdef FETCH_PERF_CNT_EN
    check("wrap.perf_fetched", perf_fetched, 64'd4);
    check("wrap.perf_stall", perf_stall_cycles, 64'd0);
`endif

    // Asynchronous reset between edges clears everything immediately
    #2;
    reset_n = 1'b0;
    #1;
    check("asyncrst.out_valid", 64'(out_valid), 64'h0);
    check("asyncrst.out_instr", 64'(out_instr), 64'(NOP));
    check("asyncrst.out_pc", out_pc, 64'h0);
    check("asyncrst.imem_addr", imem_addr, 64'h0);
    check("asyncrst.state", 64'(dbg_state), 64'(S_BOOT));
`ifdef FETCH_PERF_CNT_EN
    check("asyncrst.perf_fetched", perf_fetched, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
